// File: rtl/fir_inv_eq_if.sv
// Sample handshake and clear bundle for fir_inv_eq.
// master = sample source / sink, slave = the equalizer.
interface fir_inv_eq_if #(
  parameter int width = 16
);
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [width-1:0] Yn;
  logic                    out_valid;
  logic signed [width-1:0] Xn_hat;

  modport master (
    output clr, in_valid, Yn,
    input  in_ready, out_valid, Xn_hat
  );

  modport slave (
    input  clr, in_valid, Yn,
    output in_ready, out_valid, Xn_hat
  );
endinterface

// File: rtl/fir_inv_eq.sv
// Recursive inverse of the FIR with tap weights 2^-k and output scale 1/4.
// One sample per NUM_TAPS cycles on a shared subtractor; define FIR_INV_SAT_EN to saturate.
module fir_inv_eq #(
  parameter int width    = 16,
  parameter int NUM_TAPS = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  fir_inv_eq_if.slave bus
);
  localparam int ACCW = width + 3;
  localparam int KW   = $clog2(NUM_TAPS);
  localparam logic [KW-1:0] K_FIRST = KW'(1);
  localparam logic [KW-1:0] K_LAST  = KW'(NUM_TAPS - 1);

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_last;

  logic signed [ACCW-1:0]  r_acc;
  logic        [KW-1:0]    r_k;
  logic signed [width-1:0] r_h [1:NUM_TAPS-1];
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [width-1:0] r_xn_hat;

  logic signed [width-1:0] w_hk;
  logic signed [ACCW-1:0]  w_hext;
  logic signed [ACCW-1:0]  w_term;
  logic signed [ACCW-1:0]  w_diff;
  logic signed [width-1:0] w_fit;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    if (bus.clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ACC;
          end
        end
        S_ACC: begin
          if (r_k == K_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_hk = '0;
    for (int unsigned i = 1; i < NUM_TAPS; i++) begin
      if (r_k == KW'(i)) begin
        w_hk = r_h[i];
      end
    end
  end

  assign w_hext = {{3{w_hk[width-1]}}, w_hk};
  assign w_term = w_hext >>> r_k;
  assign w_diff = r_acc - w_term;

`ifdef FIR_INV_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {4'b0000, {(width-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {4'b1111, {(width-1){1'b0}}};

  always_comb begin
    if (w_diff > SAT_MAX) begin
      w_fit = {1'b0, {(width-1){1'b1}}};
    end else if (w_diff < SAT_MIN) begin
      w_fit = {1'b1, {(width-1){1'b0}}};
    end else begin
      w_fit = w_diff[width-1:0];
    end
  end
`else
  assign w_fit = w_diff[width-1:0];
`endif

  // acc also takes the difference on the last step; it is reloaded on the next accept.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_acc       <= '0;
      r_k         <= K_FIRST;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_xn_hat    <= '0;
      for (int unsigned j = 1; j < NUM_TAPS; j++) begin
        r_h[j] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      if (bus.clr) begin
        r_acc <= '0;
        r_k   <= K_FIRST;
        for (int unsigned j = 1; j < NUM_TAPS; j++) begin
          r_h[j] <= '0;
        end
      end else if (w_accept) begin
        r_acc <= {bus.Yn[width-1], bus.Yn, 2'b00};
        r_k   <= K_FIRST;
      end else if (r_state == S_ACC) begin
        r_acc <= w_diff;
        r_k   <= r_k + KW'(1);
        if (w_last) begin
          r_xn_hat    <= w_fit;
          r_out_valid <= 1'b1;
          r_h[1]      <= w_fit;
          for (int unsigned j = 2; j < NUM_TAPS; j++) begin
            r_h[j] <= r_h[j-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Xn_hat    = r_xn_hat;
endmodule

// File: tb/tb_fir_inv_eq.sv
// Directed-vector bench for fir_inv_eq (width=16, NUM_TAPS=4).
module tb_fir_inv_eq;
  localparam int W = 16;

`ifdef FIR_INV_SAT_EN
  localparam int EXP_POS = 32767;
  localparam int EXP_NEG = -32768;
`else
  localparam int EXP_POS = -1536;
  localparam int EXP_NEG = 0;
`endif

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  fir_inv_eq_if #(.width(W)) bus ();

  fir_inv_eq #(.width(W), .NUM_TAPS(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  // Waits for in_ready, transfers y, then waits for the out_valid pulse.
  task automatic do_sample(input logic signed [W-1:0] y, output logic signed [W-1:0] got,
                           output int acc_cyc, output int out_cyc, output bit timeout);
    int n;
    got = '0; acc_cyc = -1; out_cyc = -1; timeout = 1'b0; n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      timeout = 1'b1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.Yn       = y;
    tick();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      timeout = 1'b1;
      return;
    end
    out_cyc = cyc;
    got     = bus.Xn_hat;
  endtask

  task automatic test_reset();
    logic signed [W-1:0] got;
    int ac, oc;
    bit to;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.Yn = '0; arst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL por_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL por_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.Xn_hat !== W'(0)) begin errors++; $display("FAIL por_xn_hat: got %0d expected 0", bus.Xn_hat); end
    arst_n = 1'b1;
    tick();
    do_sample(W'(100), got, ac, oc, to);
    checks++; if (to || got !== W'(400)) begin errors++; $display("FAIL rst_first: got %0d timeout=%0b expected 400", got, to); end
    bus.in_valid = 1'b1; bus.Yn = W'(50);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_busy: got in_ready=%b expected 0", bus.in_ready); end
    arst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.Xn_hat !== W'(0)) begin errors++; $display("FAIL rst_mid_xn_hat: got %0d expected 0", bus.Xn_hat); end
    tick();
    arst_n = 1'b1;
    tick();
    do_sample(W'(100), got, ac, oc, to);
    checks++; if (to || got !== W'(400)) begin errors++; $display("FAIL rst_zero_hist: got %0d timeout=%0b expected 400", got, to); end
  endtask

  task automatic test_impulse();
    int ys[4] = '{100, 0, 0, 0};
    int ex[4] = '{400, -200, 0, 0};
    logic signed [W-1:0] got;
    int ac, oc, prev_ac;
    bit to;
    pulse_clr();
    prev_ac = 0;
    for (int i = 0; i < 4; i++) begin
      do_sample(W'(ys[i]), got, ac, oc, to);
      checks++; if (to || got !== W'(ex[i])) begin errors++; $display("FAIL impulse_x%0d: got %0d timeout=%0b expected %0d", i, got, to, ex[i]); end
      checks++; if (oc - ac !== 3) begin errors++; $display("FAIL impulse_lat%0d: got %0d expected 3", i, oc - ac); end
      if (i > 0) begin
        checks++; if (ac - prev_ac !== 4) begin errors++; $display("FAIL impulse_gap%0d: got %0d expected 4", i, ac - prev_ac); end
      end
      prev_ac = ac;
    end
  endtask

  task automatic test_overflow();
    logic signed [W-1:0] got;
    int ac, oc;
    bit to;
    pulse_clr();
    do_sample(W'(16000), got, ac, oc, to);
    checks++; if (to || got !== W'(EXP_POS)) begin errors++; $display("FAIL ovf_pos: got %0d timeout=%0b expected %0d", got, to, EXP_POS); end
    pulse_clr();
    do_sample(W'(-16384), got, ac, oc, to);
    checks++; if (to || got !== W'(EXP_NEG)) begin errors++; $display("FAIL ovf_neg: got %0d timeout=%0b expected %0d", got, to, EXP_NEG); end
  endtask

  task automatic test_clear();
    logic signed [W-1:0] got;
    int ac, oc, pulses;
    bit to;
    pulse_clr();
    do_sample(W'(100), got, ac, oc, to);
    checks++; if (to || got !== W'(400)) begin errors++; $display("FAIL clr_pre: got %0d timeout=%0b expected 400", got, to); end
    bus.in_valid = 1'b1; bus.Yn = W'(100);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_busy: got in_ready=%b expected 0", bus.in_ready); end
    pulse_clr();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b expected 1", bus.in_ready); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL clr_drop: got %0d pulses expected 0", pulses); end
    bus.in_valid = 1'b1; bus.clr = 1'b1; bus.Yn = W'(77);
    tick();
    bus.in_valid = 1'b0; bus.clr = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_same_cycle: got in_ready=%b expected 1", bus.in_ready); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL clr_same_pulses: got %0d expected 0", pulses); end
    do_sample(W'(100), got, ac, oc, to);
    checks++; if (to || got !== W'(400)) begin errors++; $display("FAIL clr_post: got %0d timeout=%0b expected 400", got, to); end
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    logic signed [W-1:0] out_q[$];
    int exp_acc[4] = '{10, 50, 90, 130};
    int exp_out[4] = '{40, 180, 260, 340};
    pulse_clr();
    for (int i = 0; i < 16; i++) begin
      bus.Yn       = W'(10 * (i + 1));
      bus.in_valid = 1'b1;
      if (bus.in_ready) acc_q.push_back(10 * (i + 1));
      if (bus.out_valid) out_q.push_back(bus.Xn_hat);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) out_q.push_back(bus.Xn_hat);
      tick();
    end
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL hs_accepts: got %0d expected 4", acc_q.size()); end
    checks++; if (out_q.size() !== acc_q.size()) begin errors++; $display("FAIL hs_count: got %0d outputs expected %0d", out_q.size(), acc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_acc[i]) begin
        errors++; $display("FAIL hs_acc%0d: got %0d expected %0d", i, (i < acc_q.size()) ? acc_q[i] : -1, exp_acc[i]);
      end
      checks++;
      if (i >= out_q.size() || out_q[i] !== W'(exp_out[i])) begin
        errors++; $display("FAIL hs_out%0d: got %0d expected %0d", i, (i < out_q.size()) ? int'(out_q[i]) : -1, exp_out[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_overflow();
    test_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
